// File: rtl/taxi_apb_if.sv
// APB bus bundle shared by masters and slaves.
// The master drives address/control/write data; the slave returns pready, prdata and pslverr.
interface taxi_apb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8
) ();
  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport mst (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slv (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/taxi_apb_cmd_master.sv
// Single-outstanding APB master: turns a valid/ready command stream into APB transfers
// and returns one response per command, with an optional ACCESS-phase timeout.
module taxi_apb_cmd_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [STRB_W-1:0] cmd_strb,
  input  logic [2:0]        cmd_prot,
  input  logic              cmd_valid,
  output logic              cmd_ready,

  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              rsp_valid,
  input  logic              rsp_ready,

  output logic [1:0]        dbg_state,

  taxi_apb_if.mst           m_apb
);

  // Handshakes: a beat moves on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the producer holds its payload stable while valid is high.

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("taxi_apb_cmd_master: DATA_W must be 8, 16, 32 or 64");
  end
  if (STRB_W != DATA_W / 8) begin : g_bad_strb_w
    $error("taxi_apb_cmd_master: STRB_W must equal DATA_W/8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int              CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t            state_q, state_d;
  logic              rdy_en_q, rdy_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [2:0]        prot_q, prot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_to_q, rsp_to_d;
  logic              timeout_hit;

  // rdy_en_q keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready   = (state_q == IDLE) && rdy_en_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign dbg_state   = state_q;

  assign m_apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign m_apb.penable = (state_q == ACCESS);
  assign m_apb.paddr   = addr_q;
  assign m_apb.pwrite  = write_q;
  assign m_apb.pwdata  = wdata_q;
  assign m_apb.pstrb   = strb_q;
  assign m_apb.pprot   = prot_q;

  // This cycle's failed wait is the one that brings the count up to TIMEOUT.
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    rdy_en_d   = 1'b1;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prot_d     = prot_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_to_d   = rsp_to_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          wdata_d = cmd_write ? cmd_data : '0;
          strb_d  = cmd_write ? cmd_strb : '0;
          prot_d  = cmd_prot;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins over a timeout landing in the same cycle.
        if (m_apb.pready) begin
          rsp_data_d = write_q ? '0 : m_apb.prdata;
          rsp_err_d  = m_apb.pslverr;
          rsp_to_d   = 1'b0;
          state_d    = RESP;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_to_d   = 1'b1;
          state_d    = RESP;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prot_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prot_q     <= prot_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

endmodule

// File: tb/tb_taxi_apb_cmd_master.sv
// Bench for taxi_apb_cmd_master: APB RAM slave model with programmable waits, errors and stalls,
// directed commands, and a response scoreboard fed from an expected queue.
module tb_taxi_apb_cmd_master;

  localparam int EXP_W = 42;  // {timeout, err, data[31:0], access_cycles[7:0]}

  logic        clk;
  logic        rst;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  dbg_state;

  taxi_apb_if #(.DATA_W(32), .ADDR_W(32), .STRB_W(4)) apb ();

  taxi_apb_cmd_master #(
    .DATA_W(32), .ADDR_W(32), .STRB_W(4), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_data(cmd_data),
    .cmd_strb(cmd_strb), .cmd_prot(cmd_prot), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .dbg_state(dbg_state),
    .m_apb(apb)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- APB RAM slave model ----------------
  logic [31:0] mem [0:15];
  logic        mem_clr;
  int          sl_wait;
  logic        sl_err;
  logic        sl_stuck;
  int          sl_cnt;

  assign apb.pready  = apb.psel && apb.penable && !sl_stuck && (sl_cnt == sl_wait);
  assign apb.pslverr = apb.pready && sl_err;
  assign apb.prdata  = mem[apb.paddr[5:2]];

  always @(posedge clk) begin
    if (apb.psel && apb.penable && !apb.pready) sl_cnt <= sl_cnt + 1;
    else sl_cnt <= 0;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (apb.psel && apb.penable && apb.pready && apb.pwrite) begin
      for (int b = 0; b < 4; b++)
        if (apb.pstrb[b]) mem[apb.paddr[5:2]][8*b +: 8] <= apb.pwdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               n_cmp;
  int               n_fail;
  logic [31:0]      cur_addr;
  logic             cur_write;
  logic [31:0]      cur_data;
  logic [3:0]       cur_strb;
  logic [2:0]       cur_prot;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int          setup_cnt;
    int          acc_cnt;
    logic        prev_hold;
    logic [33:0] rsp_snap;
    logic [71:0] apb_snap;
    logic [EXP_W-1:0] e;
    setup_cnt = 0;
    acc_cnt   = 0;
    prev_hold = 1'b0;
    rsp_snap  = '0;
    apb_snap  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        setup_cnt = 0;
        acc_cnt   = 0;
        prev_hold = 1'b0;
      end else begin
        if (apb.psel && !apb.penable) begin
          setup_cnt++;
          check("setup_paddr", apb.paddr, cur_addr);
          check("setup_pwrite", apb.pwrite, cur_write);
          check("setup_pprot", apb.pprot, cur_prot);
          check("setup_pstrb", apb.pstrb, cur_write ? cur_strb : 4'h0);
          if (cur_write) check("setup_pwdata", apb.pwdata, cur_data);
          apb_snap = {apb.paddr, apb.pwdata, apb.pstrb, apb.pprot, apb.pwrite};
        end
        if (apb.penable) begin
          check("penable_needs_psel", apb.psel, 1'b1);
          acc_cnt++;
          check("access_stable", {apb.paddr, apb.pwdata, apb.pstrb, apb.pprot, apb.pwrite}, apb_snap);
        end
        if (prev_hold) check("rsp_hold", {rsp_valid, rsp_timeout, rsp_err, rsp_data}, {1'b1, rsp_snap});
        if (rsp_valid) begin
          check("rsp_psel_low", apb.psel, 1'b0);
          check("rsp_cmd_ready_low", cmd_ready, 1'b0);
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_rsp: got data 0x%0h err %0d with empty expected queue", rsp_data, rsp_err);
            end else begin
              e = exp_q.pop_front();
              check("rsp_data", rsp_data, e[39:8]);
              check("rsp_err", rsp_err, e[40]);
              check("rsp_timeout", rsp_timeout, e[41]);
              check("access_cycles", acc_cnt, e[7:0]);
              check("setup_cycles", setup_cnt, 1);
            end
            setup_cnt = 0;
            acc_cnt   = 0;
          end
        end
        prev_hold = rsp_valid && !rsp_ready;
        rsp_snap  = {rsp_timeout, rsp_err, rsp_data};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot);
    cur_addr  = addr;
    cur_write = wr;
    cur_data  = data;
    cur_strb  = strb;
    cur_prot  = prot;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_data  = data;
    cmd_strb  = strb;
    cmd_prot  = prot;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("accept_seen", seen, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("rsp_seen", seen, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input int wt, input logic er, input logic stk,
                      input logic [31:0] e_data, input logic e_err, input logic e_to,
                      input logic [7:0] e_acc);
    sl_wait  = wt;
    sl_err   = er;
    sl_stuck = stk;
    exp_q.push_back({e_to, e_err, e_data, e_acc});
    set_cmd(addr, wr, data, strb, prot);
    wait_accept();
    wait_rsp_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic seen;
    int   gap;
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    mem_clr   = 1'b1;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_data  = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    sl_wait   = 0;
    sl_err    = 1'b0;
    sl_stuck  = 1'b0;
    cur_addr  = '0;
    cur_write = 1'b0;
    cur_data  = '0;
    cur_strb  = '0;
    cur_prot  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_psel", {apb.psel, apb.penable}, 2'b00);
    check("reset_rsp_fields", {rsp_timeout, rsp_err, rsp_data}, 34'h0);
    check("reset_state", dbg_state, 2'd0);
    @(negedge clk);
    rst     = 1'b0;
    mem_clr = 1'b0;
    #1 check("release_cmd_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    check("release_cmd_ready_high", cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // write, read back, partial-strobe write and read back
    xfer(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'd1);
    xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'b001, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'd1);
    xfer(32'h0000_0014, 1'b1, 32'h1234_5678, 4'h5, 3'b100, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'd1);
    xfer(32'h0000_0014, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 32'h0034_0078, 1'b0, 1'b0, 8'd1);
    // three waits then ready+slverr in the cycle the counter reaches the limit
    xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'b000, 3, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 8'd4);
    // slave never ready: abort after four ACCESS cycles
    xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 8'd4);
    // write with two waits, then read it back
    xfer(32'h0000_0018, 1'b1, 32'hCAFE_F00D, 4'hC, 3'b011, 2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'd3);
    xfer(32'h0000_0018, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 32'hCAFE_0000, 1'b0, 1'b0, 8'd1);

    // response back-pressure for 5 cycles with the next command already waiting
    sl_wait   = 0;
    sl_err    = 1'b0;
    sl_stuck  = 1'b0;
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF, 8'd1});
    set_cmd(32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'b000);
    wait_accept();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_rsp_seen", seen, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 32'h0, 8'd1});
    set_cmd(32'h0000_001C, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b010);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_handshake", {rsp_valid, rsp_ready}, 2'b11);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gap++;
      if (apb.psel && !apb.penable) break;
    end
    check("setup_after_handshake", gap, 2);
    cmd_valid = 1'b0;
    wait_rsp_done();
    xfer(32'h0000_001C, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 8'd1);

    // reset in the middle of ACCESS discards the transfer
    sl_stuck = 1'b1;
    set_cmd(32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'b000);
    wait_accept();
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_access", {apb.psel, apb.penable}, 2'b11);
    rst = 1'b1;
    #1;
    check("async_psel_drop", {apb.psel, apb.penable}, 2'b00);
    check("async_no_rsp", rsp_valid, 1'b0);
    check("async_cmd_ready_low", cmd_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    sl_stuck = 1'b0;
    #1 check("mid_release_cmd_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    check("mid_release_cmd_ready_high", cmd_ready, 1'b1);
    check("mid_release_no_rsp", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    xfer(32'h0000_0014, 1'b0, 32'h0, 4'h0, 3'b000, 1, 1'b0, 1'b0, 32'h0034_0078, 1'b0, 1'b0, 8'd2);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
